// File: rtl/grid_io_pkg.sv
// Shared constants and helpers for the shadowed I/O grid tile.
package grid_io_pkg;

  localparam int CFG_BITS_PER_SUBTILE = 3;

  localparam int CFG_OE   = 0;
  localparam int CFG_OREG = 1;
  localparam int CFG_IREG = 2;

  // Frame counter width; never narrower than one bit.
  function automatic int cnt_width(input int total);
    return (total <= 2) ? 1 : $clog2(total);
  endfunction

endpackage

// File: rtl/io_subtile_cell.sv
// One pad channel: optional output/input registers and direction muxing.
module io_subtile_cell
  import grid_io_pkg::*;
(
  input  logic                            prog_clk,
  input  logic                            prog_reset,
  input  logic [CFG_BITS_PER_SUBTILE-1:0] cfg,
  input  logic                            outpad,
  input  logic                            pad_i,
  output logic                            pad_o,
  output logic                            pad_oe,
  output logic                            inpad
);

  logic oq;
  logic iq;

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      oq <= 1'b0;
      iq <= 1'b0;
    end else begin
      oq <= outpad;
      iq <= pad_i;
    end
  end

  // An output-enabled pad returns 0 to the fabric rather than its own driver value.
  assign pad_oe = cfg[CFG_OE];
  assign pad_o  = cfg[CFG_OREG] ? oq : outpad;
  assign inpad  = cfg[CFG_OE] ? 1'b0 : (cfg[CFG_IREG] ? iq : pad_i);

endmodule

// File: rtl/grid_io_shadowed.sv
// Periphery I/O tile: serial config chain with a shadow register committed per full frame.
module grid_io_shadowed
  import grid_io_pkg::*;
#(
  parameter int NUM_SUBTILE = 8
) (
  input  logic                   prog_clk,
  input  logic                   prog_reset,
  input  logic                   ccff_en,
  input  logic                   ccff_head,
  output logic                   ccff_tail,
  input  logic [NUM_SUBTILE-1:0] outpad,
  output logic [NUM_SUBTILE-1:0] inpad,
  input  logic [NUM_SUBTILE-1:0] pad_i,
  output logic [NUM_SUBTILE-1:0] pad_o,
  output logic [NUM_SUBTILE-1:0] pad_oe,
  output logic                   cfg_done
);

  localparam int TOTAL = CFG_BITS_PER_SUBTILE * NUM_SUBTILE;
  localparam int CW    = cnt_width(TOTAL);
  localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);

  logic [TOTAL-1:0] chain;
  logic [TOTAL-1:0] shadow;
  logic [CW-1:0]    cnt;
  logic             commit;

  // Bit 0 is the head end, so the first bit of a frame travels to the top index.
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      chain  <= '0;
      cnt    <= '0;
      commit <= 1'b0;
    end else if (ccff_en) begin
      chain <= {chain[TOTAL-2:0], ccff_head};
      if (cnt == LAST) begin
        cnt    <= '0;
        commit <= 1'b1;
      end else begin
        cnt    <= cnt + CW'(1);
        commit <= 1'b0;
      end
    end else begin
      commit <= 1'b0;
    end
  end

  // Shadow samples the pre-edge chain, so a shift on the commit edge is harmless.
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      shadow   <= '0;
      cfg_done <= 1'b0;
    end else begin
      if (commit)
        shadow <= chain;
      if (ccff_en && cnt == '0)
        cfg_done <= 1'b0;
      else if (commit)
        cfg_done <= 1'b1;
    end
  end

  assign ccff_tail = chain[TOTAL-1];

  for (genvar k = 0; k < NUM_SUBTILE; k++) begin : g_subtile
    io_subtile_cell u_cell (
      .prog_clk  (prog_clk),
      .prog_reset(prog_reset),
      .cfg       (shadow[CFG_BITS_PER_SUBTILE*k +: CFG_BITS_PER_SUBTILE]),
      .outpad    (outpad[k]),
      .pad_i     (pad_i[k]),
      .pad_o     (pad_o[k]),
      .pad_oe    (pad_oe[k]),
      .inpad     (inpad[k])
    );
  end

endmodule

// File: tb/tb_grid_io_shadowed.sv
// Directed bench for grid_io_shadowed with 8 subtiles.
module tb_grid_io_shadowed;

  logic       prog_clk = 1'b0;
  logic       prog_reset;
  logic       ccff_en;
  logic       ccff_head;
  logic       ccff_tail;
  logic [7:0] outpad;
  logic [7:0] inpad;
  logic [7:0] pad_i;
  logic [7:0] pad_o;
  logic [7:0] pad_oe;
  logic       cfg_done;

  int checks = 0;
  int errors = 0;

  logic [23:0] frame_p;
  logic [23:0] frame_q;
  logic [23:0] frame_a;
  logic [23:0] frame_b;

  grid_io_shadowed #(.NUM_SUBTILE(8)) dut (
    .prog_clk  (prog_clk),
    .prog_reset(prog_reset),
    .ccff_en   (ccff_en),
    .ccff_head (ccff_head),
    .ccff_tail (ccff_tail),
    .outpad    (outpad),
    .inpad     (inpad),
    .pad_i     (pad_i),
    .pad_o     (pad_o),
    .pad_oe    (pad_oe),
    .cfg_done  (cfg_done)
  );

  always #5 prog_clk = ~prog_clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  // Builds a frame so that frame[i] ends up in chain[i] when shifted MSB first.
  function automatic logic [23:0] mkFrame(input logic [7:0] oe, input logic [7:0] oreg, input logic [7:0] ireg);
    logic [23:0] f;
    f = '0;
    for (int k = 0; k < 8; k++) begin
      f[3*k]   = oe[k];
      f[3*k+1] = oreg[k];
      f[3*k+2] = ireg[k];
    end
    return f;
  endfunction

  task automatic applyStimulus(input logic b);
    ccff_en   = 1'b1;
    ccff_head = b;
    @(posedge prog_clk);
    #1;
  endtask

  task automatic shiftFrame(input logic [23:0] f);
    for (int i = 23; i >= 0; i--)
      applyStimulus(f[i]);
  endtask

  task automatic idle(input int n);
    ccff_en = 1'b0;
    repeat (n) @(posedge prog_clk);
    #1;
  endtask

  task automatic pulseReset();
    ccff_en    = 1'b0;
    prog_reset = 1'b1;
    repeat (2) @(posedge prog_clk);
    #1;
    prog_reset = 1'b0;
  endtask

  initial begin
    ccff_en   = 1'b0;
    ccff_head = 1'b0;
    outpad    = 8'h00;
    pad_i     = 8'h00;
    pulseReset();

    // Reset default: all pads are combinational inputs
    pad_i  = 8'hA5;
    outpad = 8'h3C;
    #1;
    checkOutput("rst_inpad", 32'(inpad), 32'h A5);
    checkOutput("rst_pad_oe", 32'(pad_oe), 32'h00);
    checkOutput("rst_pad_o", 32'(pad_o), 32'h3C);
    checkOutput("rst_cfg_done", 32'(cfg_done), 32'h0);
    checkOutput("rst_tail", 32'(ccff_tail), 32'h0);

    // Full frame, all outputs unregistered
    shiftFrame(mkFrame(8'hFF, 8'h00, 8'h00));
    checkOutput("full_oe_at_shift24", 32'(pad_oe), 32'h00);
    checkOutput("full_done_at_shift24", 32'(cfg_done), 32'h0);
    idle(1);
    outpad = 8'h5A;
    #1;
    checkOutput("full_oe_commit", 32'(pad_oe), 32'hFF);
    checkOutput("full_done_commit", 32'(cfg_done), 32'h1);
    checkOutput("full_pad_o", 32'(pad_o), 32'h5A);
    checkOutput("full_inpad", 32'(inpad), 32'h00);

    // Registered modes: subtile 0 OREG+OE, subtile 1 IREG input
    shiftFrame(mkFrame(8'h01, 8'h01, 8'h02));
    idle(1);
    checkOutput("reg_oe", 32'(pad_oe), 32'h01);
    checkOutput("reg_done", 32'(cfg_done), 32'h1);
    outpad = 8'h00;
    pad_i  = 8'h00;
    idle(1);
    outpad = 8'hFF;
    pad_i  = 8'hFF;
    #1;
    checkOutput("reg_pad_o_before", 32'(pad_o), 32'hFE);
    checkOutput("reg_inpad_before", 32'(inpad), 32'hFC);
    idle(1);
    checkOutput("reg_pad_o_after", 32'(pad_o), 32'hFF);
    checkOutput("reg_inpad_after", 32'(inpad), 32'hFE);
    outpad = 8'h00;
    pad_i  = 8'h00;
    #1;
    checkOutput("reg_pad_o_fall_before", 32'(pad_o), 32'h01);
    checkOutput("reg_inpad_fall_before", 32'(inpad), 32'h02);
    idle(1);
    checkOutput("reg_pad_o_fall_after", 32'(pad_o), 32'h00);
    checkOutput("reg_inpad_fall_after", 32'(inpad), 32'h00);

    // Chain passthrough: first pattern reappears at the tail in order
    frame_p = 24'hC3A596;
    frame_q = 24'h5A0FF0;
    shiftFrame(frame_p);
    checkOutput("tail_shift24", 32'(ccff_tail), 32'(frame_p[23]));
    for (int j = 1; j < 24; j++) begin
      applyStimulus(frame_q[24-j]);
      checkOutput($sformatf("tail_shift%0d", 24 + j), 32'(ccff_tail), 32'(frame_p[23-j]));
    end
    applyStimulus(frame_q[0]);
    idle(1);
    checkOutput("pass_done", 32'(cfg_done), 32'h1);
    checkOutput("pass_oe_q", 32'(pad_oe), 32'h0C);

    // Glitch-free reload interrupted by reset
    shiftFrame(mkFrame(8'hFF, 8'h00, 8'h00));
    idle(1);
    checkOutput("reload_oe_old", 32'(pad_oe), 32'hFF);
    applyStimulus(1'b0);
    checkOutput("reload_done_shift1", 32'(cfg_done), 32'h0);
    checkOutput("reload_oe_shift1", 32'(pad_oe), 32'hFF);
    for (int i = 1; i < 12; i++)
      applyStimulus(1'b0);
    checkOutput("reload_oe_shift12", 32'(pad_oe), 32'hFF);
    idle(10);
    checkOutput("reload_oe_pause", 32'(pad_oe), 32'hFF);
    checkOutput("reload_done_pause", 32'(cfg_done), 32'h0);
    pulseReset();
    outpad = 8'h96;
    pad_i  = 8'h69;
    #1;
    checkOutput("reload_rst_oe", 32'(pad_oe), 32'h00);
    checkOutput("reload_rst_pad_o", 32'(pad_o), 32'h96);
    checkOutput("reload_rst_inpad", 32'(inpad), 32'h69);
    checkOutput("reload_rst_tail", 32'(ccff_tail), 32'h0);
    checkOutput("reload_rst_done", 32'(cfg_done), 32'h0);
    shiftFrame(mkFrame(8'hFF, 8'h00, 8'h00));
    checkOutput("reload_fresh_done_shift24", 32'(cfg_done), 32'h0);
    idle(1);
    checkOutput("reload_fresh_oe", 32'(pad_oe), 32'hFF);
    checkOutput("reload_fresh_done", 32'(cfg_done), 32'h1);

    // Back-to-back frames with no gap
    frame_a = mkFrame(8'h0F, 8'h00, 8'h00);
    frame_b = mkFrame(8'hF0, 8'h00, 8'h00);
    shiftFrame(frame_a);
    applyStimulus(frame_b[23]);
    checkOutput("b2b_oe_shift25", 32'(pad_oe), 32'h0F);
    checkOutput("b2b_done_shift25", 32'(cfg_done), 32'h0);
    for (int i = 22; i >= 0; i--)
      applyStimulus(frame_b[i]);
    checkOutput("b2b_oe_shift48", 32'(pad_oe), 32'h0F);
    checkOutput("b2b_done_shift48", 32'(cfg_done), 32'h0);
    idle(1);
    checkOutput("b2b_oe_commit", 32'(pad_oe), 32'hF0);
    checkOutput("b2b_done_commit", 32'(cfg_done), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/grid_io_shadowed.md
# grid_io_shadowed

Parametrised I/O grid tile, successor to the fixed 8-subtile bottom I/O tile. It provides NUM_SUBTILE pad channels fed by a configuration-chain (ccff) segment. Each subtile now has three config bits: direction, output register and input register. Config bits are shifted through a working chain and committed to a shadow register only when a full frame has been loaded, so pads never glitch during reprogramming. It sits on the fabric periphery; its ccff_head/ccff_tail splice into the global configuration chain.

## Interface
- NUM_SUBTILE, default 8, number of pad channels (>=1).
- prog_clk  in  1  sole clock; drives config shifting and the optional I/O registers.
- prog_reset  in  1  reset, synchronous, active-high.
- ccff_en  in  1  shift enable; chain advances one bit per prog_clk edge while high.
- ccff_head  in  1  serial config input.
- ccff_tail  out  1  serial config output, equal to the last working-chain bit.
- outpad  in  NUM_SUBTILE  fabric-to-pad data, one bit per subtile.
- inpad  out  NUM_SUBTILE  pad-to-fabric data.
- pad_i  in  NUM_SUBTILE  pad receiver value.
- pad_o  out  NUM_SUBTILE  pad driver value.
- pad_oe  out  NUM_SUBTILE  pad driver enable, 1 = output.
- cfg_done  out  1  high while the shadow holds a completely loaded frame.

## Operation
- TOTAL = 3*NUM_SUBTILE. Working chain `chain[0:TOTAL-1]`; chain[0] sits on the head side.
- On a shift cycle: chain[0] <= ccff_head and chain[i] <= chain[i-1]. ccff_tail = chain[TOTAL-1].
- Subtile k field: chain[3k+0] = OE, chain[3k+1] = OREG, chain[3k+2] = IREG.
  - The first bit shifted in lands at subtile NUM_SUBTILE-1 IREG.
  - The last bit shifted in lands at subtile 0 OE.
- Frame counter `cnt` runs 0..TOTAL-1 and advances only on shift cycles.
  - A shift with cnt==TOTAL-1 sets cnt to 0 and sets the one-cycle flag `commit`.
- Shadow/commit rules:
  - When commit is high: shadow <= chain and cfg_done <= 1.
  - A shift with cnt==0 (first bit of a new frame) clears cfg_done.
  - If that clear coincides with commit: the shadow still loads and cfg_done ends at 0.
- Per-subtile datapath, driven from the shadow only:
  - Output register: oq[k] <= outpad[k] every edge.
  - Input register: iq[k] <= pad_i[k] every edge.
  - pad_oe[k] = OE.
  - pad_o[k] = OREG ? oq[k] : outpad[k].
  - inpad[k] = OE ? 0 : (IREG ? iq[k] : pad_i[k]).
- Reset clears chain, shadow, cnt, commit, cfg_done, oq and iq. The effect:
  - all pads are inputs with combinational passthrough;
  - pad_o = outpad, pad_oe = 0, ccff_tail = 0.
- Reset mid-frame discards the partial frame and the previously committed shadow.
- ccff_en low freezes chain and cnt. Partial frames persist indefinitely.

## Timing
- Head to tail latency: TOTAL shift cycles; ccff_tail changes only on shift edges.
- Commit latency: if the completing shift happens at edge E, shadow and cfg_done update at edge E+1. New config is visible on pads after E+1.
- A shift at edge E+1 does not corrupt the commit, because the shadow samples the pre-edge chain.
- Registered paths (OREG, IREG): 1-cycle latency. Unregistered paths: combinational, zero cycles.
- Back-to-back frames with continuous ccff_en are supported with no gap cycle.

## Structure
- Shared package `grid_io_pkg` holds:
  - CFG_BITS_PER_SUBTILE = 3;
  - bit-index constants CFG_OE = 0, CFG_OREG = 1, CFG_IREG = 2;
  - a helper function for the TOTAL/counter width (clog2 of TOTAL, minimum 1).
- Sub-module `io_subtile_cell` implements one subtile's oq/iq registers and muxes from its 3 shadow bits. It is generated NUM_SUBTILE times.
- The top level owns the chain, the counter and the commit/shadow logic.

## Test plan
- Reset default: after reset, pad_i = 8'hA5 gives inpad = 8'hA5 combinationally; pad_oe = 0; pad_o tracks outpad; cfg_done = 0.
- Full frame, NUM_SUBTILE = 8: shift 24 bits so every subtile gets OE = 1, OREG = 0.
  - pad_oe stays 0 through shift 24.
  - pad_oe = 8'hFF and cfg_done = 1 one edge later.
  - pad_o = outpad; inpad = 0.
- Registered modes: load subtile 0 with OREG = 1, OE = 1 and subtile 1 with IREG = 1, OE = 0. pad_o[0] and inpad[1] lag outpad[0] and pad_i[1] by exactly one edge.
- Chain passthrough: shift a 24-bit pattern, then 24 more bits. ccff_tail reproduces the first pattern in order, with the first bit appearing at shift 24.
- Glitch-free reload: with a frame committed, shift 12 bits, drop ccff_en for 10 cycles, then assert prog_reset.
  - During the 12 shifts and the pause, pads keep the old config; cfg_done falls on shift 1 of the new frame.
  - After reset, all registers are zero.
- Back-to-back frames: 48 continuous shifts. The commit after shift 24 loads frame A. The coincident new-frame start leaves cfg_done = 0. cfg_done = 1 after shift 48 + 1.
